// File: rtl/pc_fetch.sv
// Instruction fetch stage: IDLE/REQ/WAIT/HOLD handshake between instruction memory and decode.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT watchdog that re-issues the fetch and sets a sticky fetch_err.
module pc_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dnpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        w_latch;
  logic        w_retire;
  logic        w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        if (imem_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_next = S_HOLD;
          w_latch      = 1'b1;
        end else if (w_timeout) begin
          w_state_next = S_REQ;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          w_state_next = S_REQ;
          w_retire     = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= 32'h0000_0000;
      r_inst  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_next;
      if (w_latch)  r_inst <= imem_rdata;
      // Low bits of the next PC are dropped so every fetch stays word aligned.
      if (w_retire) r_pc   <= dnpc & 32'hFFFF_FFFC;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_fetch_err;

  // Fires on the WAIT cycle that would bring the counter to 255.
  assign w_timeout = (r_state == S_WAIT) && !imem_rvalid && (r_tmo_cnt == 8'd254);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt   <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT)  r_tmo_cnt <= 8'd0;
      else if (!imem_rvalid)  r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_timeout)          r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign imem_req   = (r_state == S_REQ);
  assign inst_valid = (r_state == S_HOLD);
  assign imem_addr  = r_pc & 32'hFFFF_FFFC;
  assign pc         = r_pc;
  assign inst       = r_inst;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-003 dnpc  input  32  next PC produced by the next-PC stage from current pc/inst.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ready  input  1  memory accepts request this cycle.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 pc  output  32  PC of instruction currently held.
REQ-010 inst  output  32  held instruction to decode.
REQ-011 inst_valid  output  1  inst/pc valid for decode.
REQ-012 inst_ready  input  1  decode/execute retires held instruction this cycle.
REQ-013 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, HOLD; the state register is the only source of imem_req and inst_valid (pure state decode).
REQ-015 IDLE: outputs idle; unconditional transition to REQ next cycle.
REQ-016 REQ: imem_req=1, imem_addr={pc[31:2],2'b00}; imem_ready=1 -> WAIT, else remain in REQ with address held stable.
REQ-017 WAIT: imem_req=0; imem_rvalid=1 -> latch imem_rdata into inst, go to HOLD.
REQ-018 HOLD: inst_valid=1, inst and pc stable; inst_ready=1 -> pc<=dnpc with bits [1:0] cleared, go to REQ; else remain in HOLD.
REQ-019 Handshake: retire occurs only on (inst_valid & inst_ready); inst_ready in any other state is ignored.
REQ-020 imem_rvalid outside WAIT is ignored (no latch, no state change).
REQ-021 imem_ready outside REQ is ignored.
REQ-022 Latency: imem_ready at cycle N, imem_rvalid at N+k (k>=1) -> inst_valid first high at N+k+1.
REQ-023 pc wraps modulo 2^32; no overflow detection.
REQ-024 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with ready=rvalid=1 every cycle.

Reset
REQ-025 rst_n=0: state=IDLE, pc=32'h00000000, inst=32'h00000000, inst_valid=0, imem_req=0, fetch_err=0, timeout counter=0.
REQ-026 Reset mid-operation (any state) abandons the outstanding fetch; a late imem_rvalid after reset release lands outside WAIT and is ignored.
REQ-027 First request after reset release issues with imem_addr=0x00000000 in the second cycle after release (IDLE, then REQ).

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: 8-bit counter clears on entry to WAIT and increments each WAIT cycle without imem_rvalid; when it reaches 255 with no rvalid, FSM returns to REQ (re-issuing same pc) and fetch_err sets, sticky until reset.
REQ-029 FETCH_TIMEOUT_EN undefined: no counter is built, WAIT waits indefinitely, fetch_err is tied 0; the port is present in both builds.

Verification
REQ-030 Reset release, imem_ready=1, rvalid one cycle after ready, rdata=0x00000093 -> imem_addr=0x0 in REQ, inst=0x00000093, pc=0x0, inst_valid high at cycle 4 after release.
REQ-031 HOLD with dnpc=0x00000104, inst_ready pulse -> next REQ shows imem_addr=0x00000104, pc=0x00000104.
REQ-032 imem_ready low for 5 cycles in REQ -> imem_req high and imem_addr stable for all 5 cycles, one WAIT entry only.
REQ-033 inst_ready held 0 for 10 cycles in HOLD, spurious imem_rvalid with rdata=0xDEADBEEF -> inst unchanged, no new request.
REQ-034 rst_n pulsed low in WAIT, rvalid arrives 1 cycle after release -> ignored; pc=0, fetch restarts at 0x0.
REQ-035 FETCH_TIMEOUT_EN build, rvalid withheld 255 WAIT cycles -> FSM re-enters REQ with same address, fetch_err=1 and stays 1 after the following successful fetch.
